// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM states and 4x4 key layout for the keypad emulator.
package keypad_pkg;
  typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, RELEASE} state_t;
  // Nibble k holds {row, col} of hex key k.
  localparam logic [63:0] KEY_MAP = 64'hECFB_73A9_8654_210D;
  function automatic logic [3:0] key_pos(input logic [3:0] key);
    return KEY_MAP[{key, 2'b00} +: 4];
  endfunction
  function automatic logic [3:0] pos_to_key(input logic [3:0] pos);
    logic [3:0] r_key;
    r_key = '0;
    for (int k = 0; k < 16; k++)
      if (KEY_MAP[k*4 +: 4] == pos) r_key = 4'(k);
    return r_key;
  endfunction
endpackage

// File: rtl/keypad_emulator_bounce_gen.sv
// bounce_gen: one contact-bounce phase, inverting the level every TOGGLE_PERIOD cycles for i_len cycles.
module bounce_gen #(
  parameter int BOUNCE_W      = 16,
  parameter int TOGGLE_PERIOD = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_level,
  input  logic [BOUNCE_W-1:0] i_len,
  output logic                o_level,
  output logic                o_done
);
  localparam int TP_W = $clog2(TOGGLE_PERIOD + 1);
  logic [BOUNCE_W-1:0] r_left;
  logic [TP_W-1:0]     r_tp;
  logic                r_level;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_left  <= '0;
      r_tp    <= '0;
      r_level <= 1'b0;
    end else if (i_start) begin
      r_left  <= i_len - BOUNCE_W'(1);
      r_tp    <= TP_W'(TOGGLE_PERIOD - 1);
      r_level <= i_level;
    end else if (r_left != '0) begin
      r_left  <= r_left - BOUNCE_W'(1);
      r_tp    <= (r_tp == '0) ? TP_W'(TOGGLE_PERIOD - 1) : r_tp - TP_W'(1);
      r_level <= (r_tp == '0) ? !r_level : r_level;
    end
  end
  assign o_level = r_level;
  assign o_done  = (r_left == '0);
endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 matrix-keypad responder driving columns from scanner rows per timed press commands.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_W        = 24,
  parameter int BOUNCE_W      = 16,
  parameter int TOGGLE_PERIOD = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          row_i,
  output logic [3:0]          col_o,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [3:0]          cmd_key_i,
  input  logic [HOLD_W-1:0]   cmd_hold_i,
  input  logic [BOUNCE_W-1:0] cmd_bounce_i,
  output logic                pressed_o,
  output logic                done_o
);
  state_t              r_state, w_next;
  logic [1:0]          r_row, r_col;
  logic [BOUNCE_W-1:0] r_bounce;
  logic [HOLD_W-1:0]   r_cnt;
  logic                w_accept, w_bg_start, w_bg_level, w_bg_done, w_contact;
  assign cmd_ready_o = !rst && r_state == IDLE;
  assign w_accept    = cmd_valid_i && cmd_ready_o;
  always_comb begin
    w_next     = r_state;
    w_bg_start = 1'b0;
    case (r_state)
      IDLE: begin
        w_bg_start = w_accept && cmd_bounce_i != '0;
        w_next     = !w_accept ? IDLE : (cmd_bounce_i != '0 ? BOUNCE_IN : HOLD);
      end
      BOUNCE_IN: w_next = w_bg_done ? HOLD : BOUNCE_IN;
      HOLD: begin
        w_bg_start = r_cnt == '0 && r_bounce != '0;
        w_next     = r_cnt != '0 ? HOLD : (r_bounce != '0 ? BOUNCE_OUT : RELEASE);
      end
      BOUNCE_OUT: w_next = w_bg_done ? RELEASE : BOUNCE_OUT;
      RELEASE:    w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_row    <= '0;
      r_col    <= '0;
      r_bounce <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        {r_row, r_col} <= key_pos(cmd_key_i);
        r_bounce       <= cmd_bounce_i;
        r_cnt          <= (cmd_hold_i == '0) ? '0 : cmd_hold_i - HOLD_W'(1);
      end else if (r_state == HOLD && r_cnt != '0) begin
        r_cnt <= r_cnt - HOLD_W'(1);
      end
    end
  end
  // Press-edge bounce starts closed, release-edge bounce starts open.
  bounce_gen #(.BOUNCE_W(BOUNCE_W), .TOGGLE_PERIOD(TOGGLE_PERIOD)) u_bounce (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_bg_start),
    .i_level (r_state == IDLE),
    .i_len   (r_state == IDLE ? cmd_bounce_i : r_bounce),
    .o_level (w_bg_level),
    .o_done  (w_bg_done)
  );
  assign w_contact = r_state == HOLD || ((r_state == BOUNCE_IN || r_state == BOUNCE_OUT) && w_bg_level);
  assign pressed_o = w_contact;
  assign done_o    = r_state == RELEASE;
  assign col_o     = (!rst && w_contact && row_i[r_row]) ? 4'b0001 << r_col : 4'b0000;
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: randomized scoreboard bench comparing the emulator against a per-cycle press model.
module tb_keypad_emulator;
  import keypad_pkg::*;
  localparam int HOLD_W = 24;
  localparam int BOUNCE_W = 16;
  localparam int TP = 8;
  localparam logic [3:0] LAYOUT [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA}, '{4'h4, 4'h5, 4'h6, 4'hB},
                                           '{4'h7, 4'h8, 4'h9, 4'hC}, '{4'hE, 4'h0, 4'hF, 4'hD}};
  typedef struct {bit contact; bit done; logic [3:0] key;} exp_t;
  logic clk = 0, rst = 1, cmd_valid_i = 0, cmd_ready_o, pressed_o, done_o;
  logic [3:0] row_i = 0, col_o, cmd_key_i = 0, row_fix = 0;
  logic [HOLD_W-1:0] cmd_hold_i = 0;
  logic [BOUNCE_W-1:0] cmd_bounce_i = 0;
  int tests = 0, fails = 0, acc_cnt = 0, rem = 0, row_mode = 0;
  exp_t q[$];
  exp_t e;
  keypad_emulator #(.HOLD_W(HOLD_W), .BOUNCE_W(BOUNCE_W), .TOGGLE_PERIOD(TP)) dut (
    .clk(clk), .rst(rst), .row_i(row_i), .col_o(col_o), .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o), .cmd_key_i(cmd_key_i), .cmd_hold_i(cmd_hold_i),
    .cmd_bounce_i(cmd_bounce_i), .pressed_o(pressed_o), .done_o(done_o));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  function automatic logic [3:0] exp_col(input logic [3:0] key, input logic [3:0] rows, input bit on);
    logic [3:0] c;
    c = '0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (LAYOUT[r][k] == key && on && rows[r]) c = 4'b0001 << k;
    return c;
  endfunction
  function automatic logic [1:0] key_row(input logic [3:0] key);
    logic [1:0] rr;
    rr = '0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (LAYOUT[r][k] == key) rr = 2'(r);
    return rr;
  endfunction
  // Reference model: on each accepted command, queue the whole expected contact waveform.
  always @(posedge clk) begin
    if (rst) begin
      rem = 0;
      q.delete();
    end else if (rem != 0) begin
      rem--;
    end else if (cmd_valid_i) begin
      int h, b, n;
      h = (cmd_hold_i == 0) ? 1 : int'(cmd_hold_i);
      b = int'(cmd_bounce_i);
      n = 2 * b + h + 1;
      for (int t = 1; t <= n; t++) begin
        exp_t x;
        x.key = cmd_key_i;
        x.done = (t == n);
        if (t <= b) x.contact = ((t - 1) / TP) % 2 == 0;
        else if (t <= b + h) x.contact = 1;
        else if (t <= 2 * b + h) x.contact = ((t - b - h - 1) / TP) % 2 == 1;
        else x.contact = 0;
        q.push_back(x);
      end
      rem = n;
      acc_cnt++;
    end
  end
  // Monitor: one expected entry per busy cycle, idle expectations otherwise.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_col", col_o, 4'h0);
      chk("rst_ready", {3'b0, cmd_ready_o}, 4'h0);
    end else begin
      chk("ready", {3'b0, cmd_ready_o}, {3'b0, q.size() == 0});
      if (q.size() != 0) e = q.pop_front();
      else begin
        e.contact = 0;
        e.done = 0;
        e.key = 0;
      end
      chk("pressed", {3'b0, pressed_o}, {3'b0, e.contact});
      chk("done", {3'b0, done_o}, {3'b0, e.done});
      chk("col", col_o, exp_col(e.key, row_i, e.contact));
      if ($onehot(col_o)) begin
        logic [1:0] c;
        c = 0;
        for (int k = 0; k < 4; k++) if (col_o[k]) c = 2'(k);
        chk("inv_map", pos_to_key({key_row(e.key), c}), e.key);
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    case (row_mode)
      0: row_i = 4'($urandom);
      1: row_i = (row_i == 4'b1000 || row_i == 4'b0000) ? 4'b0001 : row_i << 1;
      default: row_i = row_fix;
    endcase
  end
  task automatic send(input logic [3:0] k, input int h, input int b);
    int a;
    a = acc_cnt;
    cmd_key_i = k;
    cmd_hold_i = HOLD_W'(h);
    cmd_bounce_i = BOUNCE_W'(b);
    cmd_valid_i = 1;
    for (int i = 0; i < 5000 && acc_cnt == a; i++) begin
      @(posedge clk);
      #1;
    end
    cmd_valid_i = 0;
    if (acc_cnt == a) begin
      tests++;
      fails++;
      $display("FAIL send_timeout key %h: accepted 0 expected 1", k);
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 5000 && (rem != 0 || q.size() != 0); i++) @(posedge clk);
    #1;
    if (rem != 0 || q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: pending %0d expected 0", q.size());
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    cmd_valid_i = 1;
    cmd_key_i = 4'h2;
    cmd_hold_i = 5;
    cycles(3);
    rst = 0;
    cmd_valid_i = 0;
    cycles(3);
    row_mode = 2;
    row_fix = 4'b0001;
    send(4'hA, 100, 0);
    cycles(60);
    row_fix = 4'b0010;
    drain();
    row_mode = 1;
    send(4'h5, 50, 0);
    drain();
    row_mode = 2;
    row_fix = 4'b1000;
    send(4'h0, 20, 24);
    drain();
    row_mode = 0;
    send(4'h3, 30, 4);
    send(4'h7, 0, 0);
    send(4'h9, 0, 3);
    drain();
    row_mode = 2;
    row_fix = 4'b1111;
    send(4'h8, 200, 0);
    cycles(20);
    rst = 1;
    cmd_valid_i = 1;
    cmd_key_i = 4'h2;
    cmd_hold_i = 5;
    cmd_bounce_i = 2;
    cycles(2);
    rst = 0;
    cmd_valid_i = 0;
    cycles(3);
    for (int k = 0; k < 16; k++) send(4'(k), 1 + int'($urandom_range(3)), int'($urandom_range(2)));
    drain();
    foreach (LAYOUT[i]) send(4'($urandom), int'($urandom_range(5)), 7 + i % 3);
    send(4'hC, 3, 1);
    for (int i = 0; i < 30; i++) begin
      row_mode = int'($urandom_range(1));
      send(4'($urandom), int'($urandom_range(40)), int'($urandom_range(20)));
    end
    drain();
    cycles(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Synthesizable 4x4 matrix-keypad model: the responder end of the row-scan / column-sense interface driven by the keypad scanner in lab3_top.
- Accepts "press key K for N cycles with B cycles of contact bounce" commands over a valid/ready handshake.
- Drives col_o from the scanner's row_i exactly as a physical switch closure would.
- Used in hardware-in-loop and simulation benches in place of the physical keypad.

Parameters:
- HOLD_W, 24, width of hold-duration counter and cmd_hold_i.
- BOUNCE_W, 16, width of bounce-duration counter and cmd_bounce_i.
- TOGGLE_PERIOD, 8, cycles between contact toggles during bounce; must be >= 1.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  reset, synchronous, active-high.
- row_i  input  4  row drive from scanner, active-high; bit r selects row r.
- col_o  output  4  column sense to scanner, active-high.
- cmd_valid_i  input  1  press command valid.
- cmd_ready_o  output  1  emulator can accept a command.
- cmd_key_i  input  4  hex key code to press.
- cmd_hold_i  input  HOLD_W  stable-closed duration in cycles; 0 is treated as 1.
- cmd_bounce_i  input  BOUNCE_W  bounce duration in cycles on both press and release edges; 0 means no bounce.
- pressed_o  output  1  current contact state (1 = closed).
- done_o  output  1  one-cycle pulse when a command completes.

Behaviour:
- Reset, synchronous, active-high:
  - state = IDLE; contact, done_o and counters = 0; cmd_ready_o = 1 on the cycle after rst deasserts.
  - col_o is forced to 4'b0000 combinationally while rst = 1.
- Key map, row-major, row index 0..3, column bit index 0..3:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D
  - Examples: A = (row0, col3); 5 = (row1, col1).
- col_o logic:
  - Combinational: col_o = (contact && row_i[key_row]) ? (4'b0001 << key_col) : 4'b0000.
  - Zero-cycle row-to-column latency, like a real switch.
  - Other row_i bits are ignored; several rows high still returns the column if the key's row is among them.
  - row_i = 0 gives col_o = 0.
- Handshake:
  - cmd_ready_o = 1 only in IDLE.
  - A transfer occurs on a clk edge with cmd_valid_i && cmd_ready_o.
  - On transfer, key row/col, hold and bounce are latched.
  - cmd_valid_i while busy is ignored; no queuing.
- State machine (one transition per clk edge):
  - IDLE: contact = 0. On transfer, go to BOUNCE_IN if bounce != 0, else to HOLD.
  - BOUNCE_IN: contact starts closed on entry and inverts every TOGGLE_PERIOD cycles. After exactly `bounce` cycles, go to HOLD.
  - HOLD: contact = 1 for max(hold,1) cycles. Then go to BOUNCE_OUT if bounce != 0, else to RELEASE.
  - BOUNCE_OUT: contact starts open on entry and inverts every TOGGLE_PERIOD cycles for `bounce` cycles. Then go to RELEASE.
  - RELEASE: contact = 0 for one cycle, done_o = 1, next state IDLE.
  - pressed_o = contact, registered.
- Timing:
  - First closed cycle is the cycle after the accepting edge.
  - Total busy time = 2*bounce + max(hold,1) + 1 cycles.
  - cmd_ready_o returns 1 the cycle after done_o.
- Boundaries:
  - Counters never wrap; maximum hold (2^HOLD_W - 1) and maximum bounce are honoured exactly.
  - bounce < TOGGLE_PERIOD gives a single glitch phase with no toggle.
  - rst mid-operation aborts to IDLE with no done_o pulse; col_o is 0 from the cycle rst is seen.
  - cmd_valid_i asserted during rst is not accepted.

Decomposition:
- Shared package keypad_pkg:
  - state enum (IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, RELEASE).
  - 16-entry constant key-to-{row,col} map.
  - inverse map function for bench checking.
- One sub-module, bounce_gen: down-counter plus toggle-period counter, producing the contact waveform and a phase-done flag. It is reused for BOUNCE_IN and BOUNCE_OUT with a configurable initial level.

Test Plan:
- Map check: key A, hold 100, bounce 0, row_i = 0001 -> col_o = 1000 for exactly 100 cycles starting the cycle after the accept, then 0. With row_i = 0010 during the hold -> col_o = 0000.
- Key 5, hold 50, bounce 0, scanner rotating row_i 0001→0010→0100→1000 -> col_o = 0010 only while row_i = 0010. done_o pulses at cycle 51.
- Bounce: key 0, hold 20, bounce 24, TOGGLE_PERIOD 8, row_i = 1000 -> pressed_o closed 8 / open 8 / closed 8, then closed 20, then open 8 / closed 8 / open 8. col_o = 0010 when closed. Total busy time 69 cycles.
- Handshake: second cmd_valid_i held while busy -> not accepted until the cycle after done_o, then accepted exactly once. hold = 0 -> one closed cycle.
- Reset mid-HOLD: assert rst -> col_o = 0 the same cycle, no done_o, cmd_ready_o = 1 after release.
- Sweep all 16 keys with an all-ones row_i -> col_o matches the column from the keypad_pkg map.
